xor_parity_pipe: RTL and testbench



---
 rtl/xor_parity_pkg.sv | 31 +++
 rtl/xor_parity_stage.sv | 51 +++++
 rtl/xor_parity_pipe.sv | 110 +++++++++++
 tb/tb_xor_parity_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_parity_pkg.sv
// Shared sizing helpers for the registered XOR3 parity tree.
// Combinational (elaboration-time) only.
// No handshake.
package xor_parity_pkg;

    localparam int MAX_WIDTH = 243;

    // Number of XOR3 levels needed to fold n bits into one; never below one.
    function automatic int clog3(input int n);
        int lv;
        int span;
        lv   = 0;
        span = 1;
        while (span < n) begin
            span = span * 3;
            lv   = lv + 1;
        end
        return (lv < 1) ? 1 : lv;
    endfunction

    // Bits present after k levels: each level packs groups of three into one.
    function automatic int level_width(input int width, input int k);
        int n;
        n = width;
        for (int i = 0; i < k; i++) begin
            n = (n + 2) / 3;
        end
        return n;
    endfunction

endpackage

// File: rtl/xor_parity_stage.sv
// One registered XOR3 level: N bits in, ceil(N/3) bits out, with valid/ODD/LAST sidebands.
// Latency 1 cycle.
// Loads only while EN is high; otherwise holds every register.
module xor_parity_stage #(
    parameter int N = 9
) (
    input  logic                   CLK,
    input  logic                   RN,
    input  logic                   EN,
    input  logic [N-1:0]           D_I,
    output logic [(N+2)/3-1:0]     D_O,
    input  logic                   VALID_I,
    output logic                   VALID_O,
    input  logic                   ODD_I,
    output logic                   ODD_O,
    input  logic                   LAST_I,
    output logic                   LAST_O
);

    localparam int M = (N + 2) / 3;

    logic [3*M-1:0] padded;
    logic [M-1:0]   xr;

    always_comb begin
        padded        = '0;
        padded[N-1:0] = D_I;
        xr            = '0;
        for (int i = 0; i < M; i++) begin
            xr[i] = padded[3*i] ^ padded[3*i+1] ^ padded[3*i+2];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            VALID_O <= 1'b0;
        end else if (EN) begin
            VALID_O <= VALID_I;
        end
    end

    // Payload needs no reset: it is only observed alongside a set valid.
    always_ff @(posedge CLK) begin
        if (EN) begin
            D_O    <= xr;
            ODD_O  <= ODD_I;
            LAST_O <= LAST_I;
        end
    end

endmodule

// File: rtl/xor_parity_pipe.sv
// Pipelined WIDTH-bit parity reducer with per-beat even/odd select and optional frame accumulation.
// Latency LEVELS cycles from acceptance to OUT_VALID; one beat per cycle.
// Global stall: every level freezes while OUT_VALID is high and OUT_READY is low.
module xor_parity_pipe
    import xor_parity_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int ACCUM = 0
) (
    input  logic             CLK,
    input  logic             RN,
    inout  wire              VDD,
    inout  wire              VSS,
    input  logic [WIDTH-1:0] A,
    input  logic             ODD,
    input  logic             IN_LAST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             Z,
    output logic             OUT_LAST,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int LEVELS = clog3(WIDTH);

    // Bit offset of level k inside the flattened tree bus.
    function automatic int level_offset(input int k);
        int off;
        off = 0;
        for (int i = 0; i < k; i++) begin
            off = off + level_width(WIDTH, i);
        end
        return off;
    endfunction

    localparam int ROOT      = level_offset(LEVELS);
    localparam int TREE_BITS = ROOT + 1;

    logic [TREE_BITS-1:0] tree;
    logic [LEVELS:0]      vld;
    logic [LEVELS:0]      odd_l;
    logic [LEVELS:0]      last_l;
    logic                 adv;
    logic                 root;
    logic                 out_v;
    logic                 z_raw;
    logic                 unused_supply;

    assign unused_supply = VDD ^ VSS;

    assign adv      = !OUT_VALID || OUT_READY;
    assign IN_READY = adv && RN;

    assign tree[WIDTH-1:0] = A;
    assign vld[0]          = IN_VALID;
    assign odd_l[0]        = ODD;
    assign last_l[0]       = IN_LAST;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int NI  = level_width(WIDTH, k);
        localparam int NO  = level_width(WIDTH, k + 1);
        localparam int OFI = level_offset(k);
        localparam int OFO = level_offset(k + 1);

        xor_parity_stage #(
            .N(NI)
        ) u_stage (
            .CLK     (CLK),
            .RN      (RN),
            .EN      (adv),
            .D_I     (tree[OFI +: NI]),
            .D_O     (tree[OFO +: NO]),
            .VALID_I (vld[k]),
            .VALID_O (vld[k+1]),
            .ODD_I   (odd_l[k]),
            .ODD_O   (odd_l[k+1]),
            .LAST_I  (last_l[k]),
            .LAST_O  (last_l[k+1])
        );
    end

    assign root = tree[ROOT];

    if (ACCUM != 0) begin : g_accum
        logic acc;

        // acc folds each non-LAST beat as it leaves the final level and clears
        // once the LAST beat has been taken, so Z = acc ^ r ^ ODD while it waits.
        always_ff @(posedge CLK) begin
            if (!RN) begin
                acc <= 1'b0;
            end else if (adv && vld[LEVELS]) begin
                acc <= last_l[LEVELS] ? 1'b0 : (acc ^ root);
            end
        end

        assign out_v = vld[LEVELS] && last_l[LEVELS];
        assign z_raw = acc ^ root ^ odd_l[LEVELS];
    end else begin : g_beat
        assign out_v = vld[LEVELS];
        assign z_raw = root ^ odd_l[LEVELS];
    end

    // Gating by out_v keeps Z/OUT_LAST at 0 after reset even though payload is unreset.
    assign OUT_VALID = out_v;
    assign Z         = out_v && z_raw;
    assign OUT_LAST  = out_v && last_l[LEVELS];

endmodule

// File: tb/tb_xor_parity_pipe.sv
// Bench for xor_parity_pipe: four configurations side by side, directed steps then random traffic.
module tb_xor_parity_pipe;

    localparam int NI = 4;

    function automatic int w_of(input int g);
        case (g)
            0:       return 9;
            1:       return 9;
            2:       return 10;
            default: return 1;
        endcase
    endfunction

    function automatic int acc_of(input int g);
        return (g == 1) ? 1 : 0;
    endfunction

    logic            clk = 1'b0;
    logic            rn  = 1'b0;
    logic [9:0]      a;
    logic            odd;
    logic            in_last;
    logic [NI-1:0]   in_valid;
    logic [NI-1:0]   in_ready;
    logic [NI-1:0]   z;
    logic [NI-1:0]   out_last;
    logic [NI-1:0]   out_valid;
    logic [NI-1:0]   out_ready;
    wire             vdd;
    wire             vss;

    assign vdd = 1'b1;
    assign vss = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : inst
        xor_parity_pipe #(
            .WIDTH(w_of(g)),
            .ACCUM(acc_of(g))
        ) dut (
            .CLK       (clk),
            .RN        (rn),
            .VDD       (vdd),
            .VSS       (vss),
            .A         (a[w_of(g)-1:0]),
            .ODD       (odd),
            .IN_LAST   (in_last),
            .IN_VALID  (in_valid[g]),
            .IN_READY  (in_ready[g]),
            .Z         (z[g]),
            .OUT_LAST  (out_last[g]),
            .OUT_VALID (out_valid[g]),
            .OUT_READY (out_ready[g])
        );
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected {Z, OUT_LAST} per instance in emission order.
    logic [1:0] expq [NI][$];
    logic       acc_m  [NI] = '{default: 1'b0};
    logic       hold_p [NI] = '{default: 1'b0};
    logic [1:0] hold_v [NI];
    int         out_cnt [NI] = '{default: 0};

    function automatic logic parity_of(input int g, input logic [9:0] v);
        logic [9:0] m;
        m = 10'h3FF >> (10 - w_of(g));
        return ^(v & m);
    endfunction

    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("ovld_known%0d", g), {31'd0, $isunknown(out_valid[g])}, 32'd0);
            if (!rn) begin
                chk($sformatf("rst_in_ready%0d", g), in_ready[g], 1'b0);
                expq[g].delete();
                acc_m[g]  = 1'b0;
                hold_p[g] = 1'b0;
            end else begin
                chk($sformatf("in_ready_rule%0d", g), in_ready[g], !out_valid[g] || out_ready[g]);
                if (hold_p[g])
                    chk($sformatf("hold%0d", g), {out_valid[g], z[g], out_last[g]}, {1'b1, hold_v[g]});
                if (out_valid[g] && out_ready[g]) begin
                    out_cnt[g]++;
                    chk($sformatf("out_expected%0d", g), {31'd0, expq[g].size() > 0}, 32'd1);
                    if (expq[g].size() > 0)
                        chk($sformatf("out_data%0d", g), {z[g], out_last[g]}, expq[g].pop_front());
                end
                if (in_valid[g] && in_ready[g]) begin
                    if (acc_of(g) == 0) begin
                        expq[g].push_back({parity_of(g, a) ^ odd, in_last});
                    end else if (in_last) begin
                        expq[g].push_back({acc_m[g] ^ parity_of(g, a) ^ odd, 1'b1});
                        acc_m[g] = 1'b0;
                    end else begin
                        acc_m[g] = acc_m[g] ^ parity_of(g, a);
                    end
                end
                hold_p[g] = out_valid[g] && !out_ready[g];
                hold_v[g] = {z[g], out_last[g]};
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic drive_beat(input int g, input logic [9:0] av, input logic o, input logic l);
        int n;
        a = av; odd = o; in_last = l; in_valid[g] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready[g] && n < 50);
        chk($sformatf("accept%0d", g), in_ready[g], 1'b1);
        @(posedge clk); #1;
        in_valid[g] = 1'b0;
    endtask

    // Counts cycles after the accepting edge until OUT_VALID; expects exactly lat.
    task automatic wait_out(input int g, input int lat, input logic ez, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid[g] && n < 20);
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_z"}, z[g], ez);
        chk({tag, "_last"}, out_last[g], 1'b1);
        @(posedge clk); #1;
    endtask

    int bp_n;
    int cnt0;

    initial begin
        a = 10'h1FF; odd = 1'b0; in_last = 1'b1;
        in_valid = '1; out_ready = '1;

        // Reset held two edges with traffic offered
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("rst_ovld%0d", g), out_valid[g], 1'b0);
            chk($sformatf("rst_z%0d", g), z[g], 1'b0);
            chk($sformatf("rst_olast%0d", g), out_last[g], 1'b0);
        end
        @(posedge clk); #1;
        rn = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NI; g++)
            chk($sformatf("first_accept%0d", g), in_ready[g], 1'b1);
        @(posedge clk); #1;
        in_valid = '0;
        repeat (8) @(posedge clk); #1;

        // Back-to-back beats, even then odd parity
        a = 10'h1B3; odd = 1'b0; in_last = 1'b1; in_valid[0] = 1'b1;
        @(negedge clk);
        chk("b2b_acc0", in_ready[0], 1'b1);
        @(posedge clk); #1;
        odd = 1'b1;
        @(negedge clk);
        chk("b2b_c1_vld", out_valid[0], 1'b0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("b2b_c2_vld", out_valid[0], 1'b1);
        chk("b2b_c2_z", z[0], 1'b0);
        @(negedge clk);
        chk("b2b_c3_vld", out_valid[0], 1'b1);
        chk("b2b_c3_z", z[0], 1'b1);
        @(posedge clk); #1;
        repeat (4) @(posedge clk); #1;

        // Backpressure: three stalled cycles on the first result
        cnt0 = out_cnt[0];
        out_ready[0] = 1'b0;
        fork
            begin
                drive_beat(0, 10'h001, 1'b0, 1'b0);
                drive_beat(0, 10'h003, 1'b0, 1'b0);
                drive_beat(0, 10'h007, 1'b0, 1'b0);
                drive_beat(0, 10'h00F, 1'b0, 1'b1);
            end
            begin
                bp_n = 0;
                do begin
                    @(negedge clk);
                    bp_n++;
                end while (!out_valid[0] && bp_n < 20);
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("bp_ovld", out_valid[0], 1'b1);
                    chk("bp_in_ready", in_ready[0], 1'b0);
                    chk("bp_z_held", z[0], 1'b1);
                end
                @(posedge clk); #1;
                out_ready[0] = 1'b1;
            end
        join
        repeat (10) @(negedge clk);
        chk("bp_drained", expq[0].size(), 0);
        chk("bp_count", out_cnt[0] - cnt0, 4);
        @(posedge clk); #1;

        // Frame accumulation, even then odd on the LAST beat
        cnt0 = out_cnt[1];
        drive_beat(1, 10'h001, 1'b0, 1'b0);
        drive_beat(1, 10'h003, 1'b0, 1'b0);
        drive_beat(1, 10'h007, 1'b0, 1'b1);
        wait_out(1, 2, 1'b0, "acc_even");
        drive_beat(1, 10'h001, 1'b1, 1'b0);
        drive_beat(1, 10'h003, 1'b0, 1'b0);
        drive_beat(1, 10'h007, 1'b1, 1'b1);
        wait_out(1, 2, 1'b1, "acc_odd");
        repeat (4) @(negedge clk);
        chk("acc_count", out_cnt[1] - cnt0, 2);
        @(posedge clk); #1;

        // Reset in the middle of a frame
        cnt0 = out_cnt[1];
        drive_beat(1, 10'h001, 1'b0, 1'b0);
        drive_beat(1, 10'h001, 1'b0, 1'b0);
        rn = 1'b0;
        @(posedge clk); #1;
        rn = 1'b1;
        drive_beat(1, 10'h001, 1'b0, 1'b1);
        wait_out(1, 2, 1'b1, "acc_rst");
        repeat (4) @(negedge clk);
        chk("acc_rst_count", out_cnt[1] - cnt0, 1);
        @(posedge clk); #1;

        // Width corners
        drive_beat(2, 10'h3FF, 1'b0, 1'b1);
        wait_out(2, 3, 1'b0, "w10_all_ones");
        drive_beat(2, 10'h200, 1'b0, 1'b1);
        wait_out(2, 3, 1'b1, "w10_msb");
        drive_beat(3, 10'h001, 1'b0, 1'b1);
        wait_out(3, 1, 1'b1, "w1_one");
        drive_beat(3, 10'h000, 1'b1, 1'b1);
        wait_out(3, 1, 1'b1, "w1_odd");
        repeat (4) @(posedge clk); #1;

        // Random traffic with occasional reset
        for (int c = 0; c < 600; c++) begin
            a         = 10'($urandom);
            odd       = 1'($urandom);
            in_last   = ($urandom_range(0, 2) == 0);
            in_valid  = 4'($urandom);
            out_ready = 4'($urandom);
            rn        = ($urandom_range(0, 79) != 0);
            @(posedge clk); #1;
        end
        rn = 1'b1; in_valid = '0; out_ready = '1;
        repeat (12) @(negedge clk);
        for (int g = 0; g < NI; g++)
            chk($sformatf("rand_drained%0d", g), expq[g].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
